// File: rtl/fifo_pkt_pkg.sv
// Shared framing definitions for the dual-clock FIFO packet writer and the read-side parser.
package fifo_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         SEQ_W     = 4;
    localparam int         LEN_W     = 4;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        TRAIL   = 2'd3
    } pkt_wr_state_t;

    // 16-bit header word: sync byte, sequence number, payload length.
    function automatic logic [15:0] pkt_hdr(input logic [SEQ_W-1:0] seq,
                                            input logic [LEN_W-1:0] len);
        return {SYNC_BYTE, seq, len};
    endfunction

endpackage

// File: rtl/fifo_pkt_writer.sv
// Write-domain packet framer: buffers a source packet, then pushes header/payload[/checksum] into the FIFO.
// Optional checksum trailer is enabled by defining PKT_CKSUM_EN.
module fifo_pkt_writer
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LEN    = 8
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  pkt_done,
    output logic                  busy
);

    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

    pkt_wr_state_t         state_q, state_d;
    logic [LEN_W-1:0]      count_q, count_d;
    logic [LEN_W-1:0]      rd_idx_q, rd_idx_d;
    logic [SEQ_W-1:0]      seq_q, seq_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_LEN];
    logic [DATA_WIDTH-1:0] buf_d [MAX_LEN];
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  last_q, last_d;
`ifdef PKT_CKSUM_EN
    logic [DATA_WIDTH-1:0] cksum_q, cksum_d;
`endif

    logic                  xfer_s;
    logic                  wr_fire_s;
    logic [LEN_W-1:0]      len_nxt_s;
    logic [LEN_W-1:0]      idx_nxt_s;
    logic [LEN_W-1:0]      last_idx_s;

    assign xfer_s     = s_valid && ready_q;
    // The write strobe follows fifo_full combinationally so a full FIFO freezes the framer in place.
    assign wr_fire_s  = busy_q && !fifo_full;
    assign len_nxt_s  = count_q + LEN_W'(1);
    assign idx_nxt_s  = rd_idx_q + LEN_W'(1);
    assign last_idx_s = count_q - LEN_W'(1);

    assign s_ready      = ready_q;
    assign busy         = busy_q;
    assign fifo_wr_en   = wr_fire_s;
    assign fifo_wr_data = data_q;
    assign pkt_done     = wr_fire_s && last_q;

    // Next-state, buffer and output-word computation.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        seq_d    = seq_q;
        buf_d    = buf_q;
        data_d   = data_q;
        last_d   = last_q;
`ifdef PKT_CKSUM_EN
        cksum_d  = cksum_q;
`endif

        case (state_q)
            COLLECT: begin
                if (xfer_s) begin
                    buf_d[count_q[IDX_W-1:0]] = s_data;
                    count_d                   = len_nxt_s;
`ifdef PKT_CKSUM_EN
                    cksum_d                   = cksum_q + s_data;
`endif
                    if (s_last || (len_nxt_s == MAX_LEN_C)) begin
                        state_d = HDR;
                        data_d  = DATA_WIDTH'(pkt_hdr(seq_q, len_nxt_s));
                        last_d  = 1'b0;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end

            HDR: begin
                if (wr_fire_s) begin
                    state_d  = PAYLOAD;
                    rd_idx_d = '0;
                    data_d   = buf_q[0];
`ifdef PKT_CKSUM_EN
                    last_d   = 1'b0;
`else
                    last_d   = (count_q == LEN_W'(1));
`endif
                end else begin
                    state_d = HDR;
                end
            end

            PAYLOAD: begin
                if (wr_fire_s) begin
                    if (rd_idx_q == last_idx_s) begin
`ifdef PKT_CKSUM_EN
                        state_d = TRAIL;
                        data_d  = cksum_q;
                        last_d  = 1'b1;
`else
                        state_d = COLLECT;
                        seq_d   = seq_q + SEQ_W'(1);
                        count_d = '0;
                        last_d  = 1'b0;
`endif
                    end else begin
                        rd_idx_d = idx_nxt_s;
                        data_d   = buf_q[idx_nxt_s[IDX_W-1:0]];
`ifdef PKT_CKSUM_EN
                        last_d   = 1'b0;
`else
                        last_d   = (idx_nxt_s == last_idx_s);
`endif
                    end
                end else begin
                    state_d = PAYLOAD;
                end
            end

            TRAIL: begin
`ifdef PKT_CKSUM_EN
                if (wr_fire_s) begin
                    state_d = COLLECT;
                    seq_d   = seq_q + SEQ_W'(1);
                    count_d = '0;
                    cksum_d = '0;
                    last_d  = 1'b0;
                end else begin
                    state_d = TRAIL;
                end
`else
                state_d = COLLECT;
                last_d  = 1'b0;
`endif
            end

            default: begin
                state_d = COLLECT;
                count_d = '0;
                last_d  = 1'b0;
            end
        endcase

        ready_d = (state_d == COLLECT);
        busy_d  = (state_d != COLLECT);
    end

    // State and datapath registers; reset drops any packet in flight.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            count_q  <= '0;
            rd_idx_q <= '0;
            seq_q    <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_q[i] <= '0;
            end
`ifdef PKT_CKSUM_EN
            cksum_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            seq_q    <= seq_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            last_q   <= last_d;
            buf_q    <= buf_d;
`ifdef PKT_CKSUM_EN
            cksum_q  <= cksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Directed self-checking bench for fifo_pkt_writer (default parameters); adapts to PKT_CKSUM_EN.
module tb_fifo_pkt_writer;

`ifdef PKT_CKSUM_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif

    logic        wr_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        pkt_done;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] cap_data [$];
    logic        cap_done [$];
    logic [15:0] pw [16];

    fifo_pkt_writer #(.DATA_WIDTH(16), .MAX_LEN(8)) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .pkt_done     (pkt_done),
        .busy         (busy)
    );

    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        if (fifo_wr_en === 1'b1) begin
            cap_data.push_back(fifo_wr_data);
            cap_done.push_back(pkt_done);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (s_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("send_ready", {31'h0, s_ready}, 32'h1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n);
        int c;
        c = 0;
        while (cap_data.size() < n && c < 300) begin
            tick();
            c++;
        end
        chk(tag, cap_data.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_rel_ready", {31'h0, s_ready}, 32'h1);
    endtask

    // Compares one captured packet against header/payload(pw)/checksum built from pw.
    task automatic check_pkt(input string tag, input int base, input logic [3:0] seq, input int n);
        logic [15:0] sum;
        logic [15:0] exp_w;
        int          tot;
        sum = 16'h0000;
        tot = n + 1 + TR;
        for (int k = 0; k < tot; k++) begin
            if (k == 0) begin
                exp_w = {8'hA5, seq, 4'(n)};
            end else if (k <= n) begin
                exp_w = pw[k-1];
                sum   = sum + pw[k-1];
            end else begin
                exp_w = sum;
            end
            chk(tag, {15'h0, cap_done[base+k], cap_data[base+k]}, {15'h0, 1'(k == tot - 1), exp_w});
        end
    endtask

    initial begin
        int base;
        int base2;
        int c;
        int snap;

        // Reset state
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_ready", {31'h0, s_ready}, 32'h0);
        chk("reset_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        chk("reset_done", {31'h0, pkt_done}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("release_ready", {31'h0, s_ready}, 32'h1);
        chk("release_busy", {31'h0, busy}, 32'h0);

        // 3-word packet, header presented the cycle after the closing transfer
        pw[0] = 16'h0001; pw[1] = 16'h0002; pw[2] = 16'h0003;
        base = cap_data.size();
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        chk("t1_hdr_latency", {15'h0, fifo_wr_en, fifo_wr_data}, {15'h0, 1'b1, 16'hA503});
        chk("t1_busy", {31'h0, busy}, 32'h1);
        chk("t1_not_ready", {31'h0, s_ready}, 32'h0);
        wait_writes("t1_count", base + 4 + TR);
        check_pkt("t1_word", base, 4'd0, 3);

        // Forced close at MAX_LEN, 9th word waits and becomes packet seq 1
        do_reset();
        base = cap_data.size();
        for (int i = 0; i < 8; i++) begin
            pw[i] = 16'h0010 + 16'(i);
            send(pw[i], 1'b0);
        end
        chk("t2_stall_ready", {31'h0, s_ready}, 32'h0);
        send(16'h0018, 1'b1);
        wait_writes("t2_count", base + 9 + TR + 2 + TR);
        check_pkt("t2a_word", base, 4'd0, 8);
        pw[0] = 16'h0018;
        check_pkt("t2b_word", base + 9 + TR, 4'd1, 1);

        // Backpressure for 5 cycles in PAYLOAD
        pw[0] = 16'h0021; pw[1] = 16'h0022; pw[2] = 16'h0023; pw[3] = 16'h0024;
        base = cap_data.size();
        for (int i = 0; i < 4; i++) begin
            send(pw[i], 1'(i == 3));
        end
        c = 0;
        while (cap_data.size() < base + 2 && c < 50) begin
            tick();
            c++;
        end
        chk("t3_reach_payload", cap_data.size(), base + 2);
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wr_clk);
            chk("t3_full_wr_en", {31'h0, fifo_wr_en}, 32'h0);
            chk("t3_full_hold", {16'h0, fifo_wr_data}, {16'h0, 16'h0022});
        end
        @(posedge wr_clk);
        #1;
        fifo_full = 1'b0;
        wait_writes("t3_count", base + 5 + TR);
        check_pkt("t3_word", base, 4'd2, 4);

        // Checksum wrap
        pw[0] = 16'hFFFF; pw[1] = 16'h0002;
        base = cap_data.size();
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
        wait_writes("t4_count", base + 3 + TR);
        check_pkt("t4_word", base, 4'd3, 2);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_exact_writes", cap_data.size(), base + 3 + TR);

        // 17 single-word packets, sequence wraps
        do_reset();
        base = cap_data.size();
        for (int k = 0; k < 17; k++) begin
            send(16'h0100 + 16'(k), 1'b1);
            wait_writes("t5_count", base + (k + 1) * (2 + TR));
        end
        for (int k = 0; k < 17; k++) begin
            chk("t5_hdr", {16'h0, cap_data[base + k * (2 + TR)]}, {16'h0, 8'hA5, 4'(k), 4'h1});
        end
        pw[0] = 16'h0110;
        check_pkt("t5_last_pkt", base + 16 * (2 + TR), 4'd0, 1);

        // Reset during PAYLOAD of packet 2
        do_reset();
        base = cap_data.size();
        send(16'h0031, 1'b1);
        send(16'h0032, 1'b1);
        wait_writes("t6_pre_count", base + 2 * (2 + TR));
        base2 = cap_data.size();
        send(16'h0041, 1'b0);
        send(16'h0042, 1'b0);
        send(16'h0043, 1'b1);
        c = 0;
        while (cap_data.size() < base2 + 2 && c < 50) begin
            tick();
            c++;
        end
        chk("t6_reach_payload", cap_data.size(), base2 + 2);
        rst_n = 1'b0;
        snap = cap_data.size();
        tick();
        chk("t6_rst_ready", {31'h0, s_ready}, 32'h0);
        chk("t6_rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_rel_ready", {31'h0, s_ready}, 32'h1);
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_writes", cap_data.size(), snap);
        base = cap_data.size();
        pw[0] = 16'h0051;
        send(16'h0051, 1'b1);
        wait_writes("t6_post_count", base + 2 + TR);
        check_pkt("t6_post_word", base, 4'd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_writer.md
Name: fifo_pkt_writer

Overview:
- Write-domain producer for the dual-clock FIFO.
- Accepts a valid/ready word stream and buffers up to MAX_LEN payload words.
- Frames each buffered packet as header, payload, then optional checksum trailer.
- Pushes the packet into the FIFO write port, stalling on full.
- Sits between the wr_clk-domain source logic and the FIFO's wr_en/wr_data/full pins.

Parameters:
- DATA_WIDTH, 16, word width; must be >= 16.
- MAX_LEN, 8, maximum payload words per packet; legal range 1..15.

Ports:
- wr_clk  in  1  write-domain clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  source word valid.
- s_data  in  DATA_WIDTH  source word.
- s_last  in  1  source word closes the packet.
- s_ready  out  1  block accepts a source word this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  DATA_WIDTH  FIFO write word.
- pkt_done  out  1  one-cycle pulse when the last word of a packet is written.
- busy  out  1  high in any state other than COLLECT.

Behaviour:
- Reset values:
  - state = COLLECT, count = 0, seq = 0, cksum = 0.
  - fifo_wr_en = 0, pkt_done = 0, busy = 0.
  - s_ready = 0 while rst_n is low; s_ready = 1 from the first cycle after deassertion.
- Source accept: a transfer occurs on a cycle with s_valid && s_ready.
- COLLECT state:
  - s_ready = 1.
  - Each transfer writes s_data into buf[count], increments count and adds s_data to cksum (modulo 2^DATA_WIDTH, carry discarded).
  - Go to HDR when a transfer has s_last = 1, or when a transfer makes count == MAX_LEN (forced close; s_last ignored).
- HDR, PAYLOAD, TRAIL states:
  - s_ready = 0.
  - fifo_wr_en = !fifo_full, combinational. A word advances only on a cycle with fifo_wr_en = 1; otherwise fifo_wr_data holds its value.
- HDR: fifo_wr_data = {SYNC 8'hA5, seq[3:0], len[3:0]}, zero-extended at the MSB. len = count, which is 1..MAX_LEN. After the write, go to PAYLOAD with rd_idx = 0.
- PAYLOAD:
  - fifo_wr_data = buf[rd_idx]; increment rd_idx per write.
  - After writing buf[len-1], go to TRAIL if PKT_CKSUM_EN is defined, otherwise close the packet.
- TRAIL: fifo_wr_data = cksum; after the write, close the packet.
- Close: pkt_done pulses in the cycle of the final write. On the next edge: seq increments (wraps 15 -> 0), count = 0, cksum = 0, state = COLLECT.
- Latency: the header is presented the cycle after the closing transfer. With no backpressure, a packet of N words takes N+2 write cycles with the trailer, N+1 without.
- Zero-length packets cannot exist; the first word always counts.
- fifo_full asserted mid-packet: freeze in place, no word skipped or duplicated.
- Reset mid-packet: the packet is dropped, seq returns to 0, and no further writes occur.

Optional Feature:
- Macro: PKT_CKSUM_EN.
- Defined: TRAIL state and checksum accumulator are present; each packet carries a trailer word equal to the sum of its payload words mod 2^DATA_WIDTH.
- Undefined: no TRAIL state and no accumulator logic. The packet ends after the last payload word and pkt_done pulses on that write. Header format is unchanged.

Decomposition:
- Shared package fifo_pkt_pkg holds:
  - SYNC_BYTE = 8'hA5.
  - Header field widths: SEQ_W = 4, LEN_W = 4.
  - typedef enum pkt_wr_state_t {COLLECT, HDR, PAYLOAD, TRAIL}.
  - Used by this block and the future read-side parser.
- No sub-module: the payload buffer is a local MAX_LEN-entry array inside the block.

Test Plan:
- 3-word packet 0x0001, 0x0002, 0x0003 (s_last on the 3rd), seq 0, no backpressure:
  - FIFO receives 0xA503, 0x0001, 0x0002, 0x0003, 0x0006.
  - pkt_done pulses once, on the 0x0006 write.
- 9 words with no s_last, MAX_LEN = 8:
  - Packet 0 is forced closed at 8 words, header 0xA508.
  - The 9th word waits (s_ready = 0) and starts packet 1, whose header has seq = 1.
- fifo_full held high for 5 cycles mid-PAYLOAD: fifo_wr_en = 0 throughout, data held, and the FIFO sequence is unchanged after release.
- Payload 0xFFFF, 0x0002 with PKT_CKSUM_EN defined: trailer 0x0001. With the macro undefined, exactly 3 writes occur.
- 17 single-word packets: header seq runs 0..15 then 0 (17th header 0xA501).
- rst_n pulsed low during PAYLOAD of packet 2:
  - No writes after the pulse.
  - The next packet's header carries seq = 0.
  - s_ready = 0 during reset and 1 the cycle after.
